// File: rtl/rf_scoreboard_pkg.sv
// Register IDs, register-bus width and small helpers shared by the register scoreboard.
// Pure declarations: no logic, no latency or backpressure.
`ifndef REGBUS
`define REGBUS 4
`endif

package rf_scoreboard_pkg;

  typedef logic [`REGBUS-1:0] reg_id_t;

  localparam int NUM_REGS = 15;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t R8    = 4'h8;
  localparam reg_id_t R9    = 4'h9;
  localparam reg_id_t R10   = 4'hA;
  localparam reg_id_t R11   = 4'hB;
  localparam reg_id_t R12   = 4'hC;
  localparam reg_id_t R13   = 4'hD;
  localparam reg_id_t R14   = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_VALE = 2'b01,
    FWD_VALM = 2'b10
  } fwd_sel_e;

  // Number of the two destination fields naming register r (0, 1 or 2).
  function automatic logic [1:0] id_hits(input reg_id_t a, input reg_id_t b, input reg_id_t r);
    return {1'b0, a == r} + {1'b0, b == r};
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Issue / writeback / status bundle of the register scoreboard; fwd selects exist only
// when RF_SCOREBOARD_FWD_EN is defined. master = pipeline side, slave = scoreboard.
interface rf_scoreboard_if;
  import rf_scoreboard_pkg::*;

  logic                issue_valid;
  logic                issue_ready;
  reg_id_t             issue_srcA;
  reg_id_t             issue_srcB;
  reg_id_t             issue_dstE;
  reg_id_t             issue_dstM;
  logic                wbE_valid;
  reg_id_t             wbE_dst;
  logic                wbM_valid;
  reg_id_t             wbM_dst;
  logic                retire;
  logic                hazardA;
  logic                hazardB;
  logic [NUM_REGS-1:0] busy_vec;
  logic [2:0]          outstanding;
  logic [15:0]         stall_cnt;
  logic                err;
`ifdef RF_SCOREBOARD_FWD_EN
  logic [1:0]          fwdA_sel;
  logic [1:0]          fwdB_sel;
`endif

  modport master (
    output issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
           wbE_valid, wbE_dst, wbM_valid, wbM_dst, retire,
    input  issue_ready, hazardA, hazardB, busy_vec, outstanding, stall_cnt, err
`ifdef RF_SCOREBOARD_FWD_EN
    , input fwdA_sel, fwdB_sel
`endif
  );

  modport slave (
    input  issue_valid, issue_srcA, issue_srcB, issue_dstE, issue_dstM,
           wbE_valid, wbE_dst, wbM_valid, wbM_dst, retire,
    output issue_ready, hazardA, hazardB, busy_vec, outstanding, stall_cnt, err
`ifdef RF_SCOREBOARD_FWD_EN
    , output fwdA_sel, fwdB_sel
`endif
  );

endinterface

// File: rtl/rf_scoreboard_pend_ctr.sv
// Saturating pending-write counter: count' = count + inc - dec, one cycle.
// Underflow holds the value and flags unf; overflow clamps to all-ones and flags ovf.
module pend_ctr
  import rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W+1:0] CMAX = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W+1:0] sum, diff;

  always_comb begin
    sum     = {2'b00, count_q} + {{CNT_W{1'b0}}, inc};
    diff    = sum - {{CNT_W{1'b0}}, dec};
    count_d = count_q;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (sum < {{CNT_W{1'b0}}, dec}) begin
      unf = 1'b1;
    end else if (diff > CMAX) begin
      count_d = '1;
      ovf     = 1'b1;
    end else begin
      count_d = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Register scoreboard: per-register pending-write counters, issue hazard/ready, in-flight
// limit; hazards/ready are combinational, state updates next edge. RF_SCOREBOARD_FWD_EN adds forwarding.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic           clock,
  input  logic           reset,
  rf_scoreboard_if.slave sb
);

  localparam logic [2:0] MAX_OUT_V = 3'(MAX_OUT);

  logic [CNT_W-1:0]    cnt   [NUM_REGS];
  logic [1:0]          inc_v [NUM_REGS];
  logic [1:0]          dec_v [NUM_REGS];
  logic [NUM_REGS-1:0] ovf_v, unf_v, busy;
  logic [15:0]         busy16;
  logic                fire, ready, haz_a, haz_b, retire_unf;
  logic [2:0]          out_q, out_d;
  logic [15:0]         stall_q, stall_d;
  logic                err_q, err_d;

  // RNONE never matches a counter index, so writebacks to it drop out here.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam reg_id_t RID = reg_id_t'(g);
    assign inc_v[g] = fire ? id_hits(sb.issue_dstE, sb.issue_dstM, RID) : 2'd0;
    assign dec_v[g] = {1'b0, sb.wbE_valid && (sb.wbE_dst == RID)}
                    + {1'b0, sb.wbM_valid && (sb.wbM_dst == RID)};
    assign busy[g]  = (cnt[g] != '0);

    pend_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clock (clock),
      .reset (reset),
      .inc   (inc_v[g]),
      .dec   (dec_v[g]),
      .count (cnt[g]),
      .ovf   (ovf_v[g]),
      .unf   (unf_v[g])
    );
  end

  assign busy16 = {1'b0, busy};

`ifdef RF_SCOREBOARD_FWD_EN
  logic [NUM_REGS-1:0] one;
  logic [15:0]         one16;
  logic                hit_ea, hit_ma, hit_eb, hit_mb;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_one
    assign one[g] = (cnt[g] == CNT_W'(1));
  end
  assign one16 = {1'b0, one};

  assign hit_ea = sb.wbE_valid && (sb.wbE_dst == sb.issue_srcA) && (sb.issue_srcA != RNONE);
  assign hit_ma = sb.wbM_valid && (sb.wbM_dst == sb.issue_srcA) && (sb.issue_srcA != RNONE);
  assign hit_eb = sb.wbE_valid && (sb.wbE_dst == sb.issue_srcB) && (sb.issue_srcB != RNONE);
  assign hit_mb = sb.wbM_valid && (sb.wbM_dst == sb.issue_srcB) && (sb.issue_srcB != RNONE);

  // The last pending write landing this cycle can be bypassed instead of stalled.
  assign haz_a = busy16[sb.issue_srcA] && !(one16[sb.issue_srcA] && (hit_ea || hit_ma));
  assign haz_b = busy16[sb.issue_srcB] && !(one16[sb.issue_srcB] && (hit_eb || hit_mb));

  assign sb.fwdA_sel = hit_ma ? FWD_VALM : (hit_ea ? FWD_VALE : FWD_RF);
  assign sb.fwdB_sel = hit_mb ? FWD_VALM : (hit_eb ? FWD_VALE : FWD_RF);
`else
  assign haz_a = busy16[sb.issue_srcA];
  assign haz_b = busy16[sb.issue_srcB];
`endif

  assign ready = !haz_a && !haz_b && ((out_q < MAX_OUT_V) || sb.retire);
  assign fire  = sb.issue_valid && ready;

  always_comb begin
    out_d      = out_q;
    retire_unf = 1'b0;
    if (fire && !sb.retire) begin
      out_d = out_q + 3'd1;
    end else if (!fire && sb.retire) begin
      if (out_q == 3'd0) retire_unf = 1'b1;
      else               out_d = out_q - 3'd1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (sb.issue_valid && !ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  assign err_d = err_q || (|ovf_v) || (|unf_v) || retire_unf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.hazardA     = haz_a;
  assign sb.hazardB     = haz_b;
  assign sb.busy_vec    = busy;
  assign sb.outstanding = out_q;
  assign sb.stall_cnt   = stall_q;
  assign sb.err         = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed vector table plus hand sequences for reset, error, saturation and forwarding.
module tb_rf_scoreboard;
  import rf_scoreboard_pkg::*;

  localparam logic    T = 1'b1;
  localparam logic    F = 1'b0;
  localparam reg_id_t N = RNONE;

  typedef struct {
    logic        iv;
    reg_id_t     a, b, e, m;
    logic        we;
    reg_id_t     wed;
    logic        wm;
    reg_id_t     wmd;
    logic        ret;
    logic        ha, hb, rdy;
    logic [14:0] busy;
    logic [2:0]  outs;
    logic        er;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vt [27];

  always #5 clock = ~clock;

  rf_scoreboard_if sb_if ();

  rf_scoreboard #(.MAX_OUT(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if)
  );

  function automatic vec_t mk(input logic iv, input reg_id_t a, input reg_id_t b,
                              input reg_id_t e, input reg_id_t m, input logic we,
                              input reg_id_t wed, input logic wm, input reg_id_t wmd,
                              input logic ret, input logic ha, input logic hb,
                              input logic rdy, input logic [14:0] busy,
                              input logic [2:0] outs, input logic er);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.e = e; v.m = m;
    v.we = we; v.wed = wed; v.wm = wm; v.wmd = wmd; v.ret = ret;
    v.ha = ha; v.hb = hb; v.rdy = rdy; v.busy = busy; v.outs = outs; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input reg_id_t a, input reg_id_t b, input reg_id_t e,
                       input reg_id_t m, input logic we, input reg_id_t wed, input logic wm,
                       input reg_id_t wmd, input logic ret);
    sb_if.issue_valid = iv;
    sb_if.issue_srcA  = a;
    sb_if.issue_srcB  = b;
    sb_if.issue_dstE  = e;
    sb_if.issue_dstM  = m;
    sb_if.wbE_valid   = we;
    sb_if.wbE_dst     = wed;
    sb_if.wbM_valid   = wm;
    sb_if.wbM_dst     = wmd;
    sb_if.retire      = ret;
  endtask

  task automatic idle();
    drive(F, N, N, N, N, F, N, F, N, F);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    //          iv a    b    e    m     we wed  wm wmd  ret ha hb rdy busy      out  err
    vt[0]  = mk(F, N,   N,   N,   N,    F, N,   F, N,   F,  F, F, T, 15'h0000, 3'd0, F);
    vt[1]  = mk(T, N,   N,   RRAX,N,    F, N,   F, N,   F,  F, F, T, 15'h0001, 3'd1, F);
    vt[2]  = mk(T, RRAX,N,   N,   N,    F, N,   F, N,   F,  T, F, F, 15'h0001, 3'd1, F);
    vt[3]  = mk(F, N,   N,   N,   N,    T, RRAX,F, N,   F,  F, F, T, 15'h0000, 3'd1, F);
    vt[4]  = mk(T, RRAX,N,   N,   N,    F, N,   F, N,   F,  F, F, T, 15'h0000, 3'd2, F);
    vt[5]  = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd1, F);
    vt[6]  = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd0, F);
    vt[7]  = mk(T, N,   N,   RRSP,RRSP, F, N,   F, N,   F,  F, F, T, 15'h0010, 3'd1, F);
    vt[8]  = mk(F, N,   RRSP,N,   N,    T, RRSP,F, N,   F,  F, T, F, 15'h0010, 3'd1, F);
    vt[9]  = mk(F, N,   N,   N,   N,    F, N,   T, RRSP,F,  F, F, T, 15'h0000, 3'd1, F);
    vt[10] = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd0, F);
    vt[11] = mk(T, N,   N,   RRBX,N,    F, N,   F, N,   F,  F, F, T, 15'h0008, 3'd1, F);
    vt[12] = mk(T, N,   N,   N,   N,    F, N,   F, N,   F,  F, F, T, 15'h0008, 3'd2, F);
    vt[13] = mk(T, N,   N,   N,   N,    F, N,   F, N,   F,  F, F, T, 15'h0008, 3'd3, F);
    vt[14] = mk(T, N,   N,   N,   N,    F, N,   F, N,   F,  F, F, T, 15'h0008, 3'd4, F);
    vt[15] = mk(T, N,   N,   N,   N,    F, N,   F, N,   F,  F, F, F, 15'h0008, 3'd4, F);
    vt[16] = mk(T, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0008, 3'd4, F);
    vt[17] = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0008, 3'd3, F);
    vt[18] = mk(T, N,   RRBX,N,   N,    F, N,   F, N,   F,  F, T, F, 15'h0008, 3'd3, F);
    vt[19] = mk(F, N,   N,   N,   N,    F, N,   T, RRBX,F,  F, F, T, 15'h0000, 3'd3, F);
    vt[20] = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd2, F);
    vt[21] = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd1, F);
    vt[22] = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd0, F);
    vt[23] = mk(T, N,   N,   RRDI,N,    F, N,   F, N,   F,  F, F, T, 15'h0080, 3'd1, F);
    vt[24] = mk(T, N,   N,   RRDI,N,    T, RRDI,F, N,   F,  F, F, T, 15'h0080, 3'd2, F);
    vt[25] = mk(F, N,   N,   N,   N,    F, N,   T, RRDI,T,  F, F, T, 15'h0000, 3'd1, F);
    vt[26] = mk(F, N,   N,   N,   N,    F, N,   F, N,   T,  F, F, T, 15'h0000, 3'd0, F);

    idle();
    do_reset();
    chk("reset stall_cnt", 32'(sb_if.stall_cnt), 32'h0);
    chk("reset issue_ready", 32'(sb_if.issue_ready), 32'h1);

    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      drive(vt[i].iv, vt[i].a, vt[i].b, vt[i].e, vt[i].m,
            vt[i].we, vt[i].wed, vt[i].wm, vt[i].wmd, vt[i].ret);
      #1;
      chk($sformatf("v%0d hazardA", i), 32'(sb_if.hazardA), 32'(vt[i].ha));
      chk($sformatf("v%0d hazardB", i), 32'(sb_if.hazardB), 32'(vt[i].hb));
      chk($sformatf("v%0d issue_ready", i), 32'(sb_if.issue_ready), 32'(vt[i].rdy));
      step();
      chk($sformatf("v%0d busy_vec", i), 32'(sb_if.busy_vec), 32'(vt[i].busy));
      chk($sformatf("v%0d outstanding", i), 32'(sb_if.outstanding), 32'(vt[i].outs));
      chk($sformatf("v%0d err", i), 32'(sb_if.err), 32'(vt[i].er));
    end
    chk("table stall_cnt", 32'(sb_if.stall_cnt), 32'd3);

    // Writeback to an idle register, then retire with nothing in flight.
    do_reset();
    @(negedge clock);
    drive(F, N, N, N, N, F, N, T, RRCX, F);
    step();
    chk("wb idle err", 32'(sb_if.err), 32'h1);
    chk("wb idle busy", 32'(sb_if.busy_vec), 32'h0);
    @(negedge clock);
    idle();
    repeat (3) step();
    chk("err sticky", 32'(sb_if.err), 32'h1);
    do_reset();
    chk("err cleared", 32'(sb_if.err), 32'h0);
    @(negedge clock);
    drive(F, N, N, N, N, F, N, F, N, T);
    step();
    chk("retire empty err", 32'(sb_if.err), 32'h1);
    chk("retire empty outstanding", 32'(sb_if.outstanding), 32'h0);

    // Asynchronous reset in mid-operation, then a stale writeback.
    do_reset();
    @(negedge clock);
    drive(T, N, N, RRAX, N, F, N, F, N, F);
    step();
    chk("pre-reset busy", 32'(sb_if.busy_vec), 32'h1);
    @(negedge clock);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("async reset busy", 32'(sb_if.busy_vec), 32'h0);
    chk("async reset outstanding", 32'(sb_if.outstanding), 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(F, N, N, N, N, T, RRAX, F, N, F);
    step();
    chk("stale wb err", 32'(sb_if.err), 32'h1);

    // Counter saturation: 8 double issues to R8 push past 15.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      drive(T, N, N, R8, R8, F, N, F, N, F);
      step();
      @(negedge clock);
      drive(F, N, N, N, N, F, N, F, N, T);
      step();
    end
    chk("pre-sat err", 32'(sb_if.err), 32'h0);
    @(negedge clock);
    drive(T, N, N, R8, R8, F, N, F, N, F);
    step();
    chk("sat err", 32'(sb_if.err), 32'h1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      drive(F, N, N, N, N, T, R8, F, N, F);
      step();
    end
    chk("sat 14 wb busy8", 32'(sb_if.busy_vec[8]), 32'h1);
    step();
    chk("sat 15 wb busy8", 32'(sb_if.busy_vec[8]), 32'h0);

    // Long stall on a busy srcB.
    do_reset();
    chk("stall reset", 32'(sb_if.stall_cnt), 32'h0);
    @(negedge clock);
    drive(T, N, N, N, RRBP, F, N, F, N, F);
    step();
    @(negedge clock);
    drive(T, N, RRBP, N, N, F, N, F, N, F);
    repeat (3) step();
    chk("stall 3", 32'(sb_if.stall_cnt), 32'd3);
    repeat (70000) @(posedge clock);
    #1;
    chk("stall saturated", 32'(sb_if.stall_cnt), 32'hFFFF);
    chk("stall outstanding", 32'(sb_if.outstanding), 32'd1);
    chk("stall busy", 32'(sb_if.busy_vec), 32'h0020);

`ifdef RF_SCOREBOARD_FWD_EN
    do_reset();
    @(negedge clock);
    drive(T, N, N, RRDX, RRSI, F, N, F, N, F);
    step();
    @(negedge clock);
    drive(T, RRDX, N, N, N, T, RRDX, F, N, F);
    #1;
    chk("fwd hazardA", 32'(sb_if.hazardA), 32'h0);
    chk("fwd fwdA_sel", 32'(sb_if.fwdA_sel), 32'h1);
    chk("fwd issue_ready", 32'(sb_if.issue_ready), 32'h1);
    step();
    chk("fwd outstanding", 32'(sb_if.outstanding), 32'd2);
    @(negedge clock);
    drive(T, N, RRSI, N, N, F, N, T, RRSI, F);
    #1;
    chk("fwd hazardB", 32'(sb_if.hazardB), 32'h0);
    chk("fwd fwdB_sel", 32'(sb_if.fwdB_sel), 32'h2);
    step();
    chk("fwd busy", 32'(sb_if.busy_vec), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
